// File: rtl/serial2parallel_chain_if.sv
// Signal bundle for one serial2parallel_chain node: the serial input side,
// the captured word and status, and the forwarded serial output side.
interface serial2parallel_chain_if #(
   parameter int WIDTH = 30
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             in_data;
   logic             in_clk;
   logic             store;
   logic [WIDTH-1:0] output_data;
   logic             frame_valid;
   logic             short_frame;
   logic [CW-1:0]    bit_count;
   logic             out_data;
   logic             out_clk;
   logic             out_store;

   modport master (
      output in_data, in_clk, store,
      input  output_data, frame_valid, short_frame, bit_count,
             out_data, out_clk, out_store
   );

   modport slave (
      input  in_data, in_clk, store,
      output output_data, frame_valid, short_frame, bit_count,
             out_data, out_clk, out_store
   );
endinterface

// File: rtl/serial2parallel_chain.sv
// Daisy-chainable serial-to-parallel receiver: fills its own WIDTH-bit word,
// then forwards further bits and the store strobe to the next node.
module serial2parallel_chain #(
   parameter int WIDTH     = 30,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic                    clk,
   input logic                    rst,
   serial2parallel_chain_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {FILL, FULL} state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg, sreg_n, shifted;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] word, word_n;
   logic             fv, fv_n;
   logic             sf, sf_n;
   logic             odat, odat_n;
   logic             oclk, oclk_n;
   logic             ost, ost_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
         word <= '0;
         fv   <= 1'b0;
         sf   <= 1'b0;
         odat <= 1'b0;
         oclk <= 1'b0;
         ost  <= 1'b0;
      end else begin
         sreg <= sreg_n;
         cnt  <= cnt_n;
         word <= word_n;
         fv   <= fv_n;
         sf   <= sf_n;
         odat <= odat_n;
         oclk <= oclk_n;
         ost  <= ost_n;
      end
   end

   always_comb begin
      if (MSB_FIRST)
         shifted = {sreg[WIDTH-2:0], bus.in_data};
      else
         shifted = {bus.in_data, sreg[WIDTH-1:1]};
   end

   always_comb begin
      state  = (cnt == CW'(WIDTH)) ? FULL : FILL;
      sreg_n = sreg;
      cnt_n  = cnt;
      word_n = word;
      fv_n   = 1'b0;
      sf_n   = sf;
      odat_n = odat;
      oclk_n = 1'b0;
      ost_n  = bus.store;
      if (bus.store) begin
         if (state == FULL) begin
            word_n = sreg;
            fv_n   = 1'b1;
            sf_n   = 1'b0;
         end else begin
            sf_n   = 1'b1;
         end
         cnt_n = '0;
         // A bit strobed with store opens the next frame and is never forwarded.
         if (bus.in_clk) begin
            sreg_n = shifted;
            cnt_n  = CW'(1);
         end
      end else if (bus.in_clk) begin
         if (state == FILL) begin
            sreg_n = shifted;
            cnt_n  = cnt + CW'(1);
         end else begin
            odat_n = bus.in_data;
            oclk_n = 1'b1;
         end
      end
   end

   assign bus.output_data = word;
   assign bus.frame_valid = fv;
   assign bus.short_frame = sf;
   assign bus.bit_count   = cnt;
   assign bus.out_data    = odat;
   assign bus.out_clk     = oclk;
   assign bus.out_store   = ost;
endmodule

// File: tb/tb_serial2parallel_chain.sv
// Bench: two nodes (30-bit LSB-first, 8-bit MSB-first) share one stimulus and
// are compared every cycle against a frame-level reference model.
module tb_serial2parallel_chain;
   logic clk = 1'b0;
   logic rst;
   logic din, ic, st;

   int n_cmp = 0;
   int n_err = 0;

   serial2parallel_chain_if #(.WIDTH(30)) ia ();
   serial2parallel_chain_if #(.WIDTH(8))  ib ();

   assign ia.in_data = din;
   assign ia.in_clk  = ic;
   assign ia.store   = st;
   assign ib.in_data = din;
   assign ib.in_clk  = ic;
   assign ib.store   = st;

   serial2parallel_chain #(.WIDTH(30), .MSB_FIRST(1'b0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   serial2parallel_chain #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   always #5 clk = ~clk;

   // Reference state: the bits received in the current frame, in arrival order.
   logic [63:0] fb[2];
   int          fc[2];
   logic [63:0] m_od[2];
   bit          m_fv[2], m_sf[2], m_odat[2], m_oc[2], m_os[2];

   task automatic model_clear(input int k);
      fb[k] = '0; fc[k] = 0; m_od[k] = '0;
      m_fv[k] = 0; m_sf[k] = 0; m_odat[k] = 0; m_oc[k] = 0; m_os[k] = 0;
   endtask

   task automatic model_step(input int k, input int w, input bit msb);
      logic [63:0] wd;
      wd = '0;
      m_fv[k] = 0;
      m_oc[k] = 0;
      m_os[k] = st;
      if (st) begin
         if (fc[k] == w) begin
            for (int i = 0; i < w; i++) wd[msb ? (w - 1 - i) : i] = fb[k][i];
            m_od[k] = wd;
            m_fv[k] = 1;
            m_sf[k] = 0;
         end else begin
            m_sf[k] = 1;
         end
         fb[k] = '0;
         fc[k] = 0;
         if (ic) begin
            fb[k][0] = din;
            fc[k] = 1;
         end
      end else if (ic) begin
         if (fc[k] < w) begin
            fb[k][fc[k]] = din;
            fc[k]++;
         end else begin
            m_odat[k] = din;
            m_oc[k] = 1;
         end
      end
   endtask

   initial begin
      model_clear(0);
      model_clear(1);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_clear(0);
         model_clear(1);
      end else begin
         model_step(0, 30, 1'b0);
         model_step(1, 8, 1'b1);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   int         pb_n = 0;
   logic [3:0] pb_bits = '0;

   always @(negedge clk) begin
      chk("A.output_data", 64'(ia.output_data), m_od[0]);
      chk("A.frame_valid", 64'(ia.frame_valid), 64'(m_fv[0]));
      chk("A.short_frame", 64'(ia.short_frame), 64'(m_sf[0]));
      chk("A.bit_count",   64'(ia.bit_count),   64'(fc[0]));
      chk("A.out_clk",     64'(ia.out_clk),     64'(m_oc[0]));
      chk("A.out_data",    64'(ia.out_data),    64'(m_odat[0]));
      chk("A.out_store",   64'(ia.out_store),   64'(m_os[0]));
      chk("B.output_data", 64'(ib.output_data), m_od[1]);
      chk("B.frame_valid", 64'(ib.frame_valid), 64'(m_fv[1]));
      chk("B.short_frame", 64'(ib.short_frame), 64'(m_sf[1]));
      chk("B.bit_count",   64'(ib.bit_count),   64'(fc[1]));
      chk("B.out_clk",     64'(ib.out_clk),     64'(m_oc[1]));
      chk("B.out_data",    64'(ib.out_data),    64'(m_odat[1]));
      chk("B.out_store",   64'(ib.out_store),   64'(m_os[1]));
      if (ib.out_clk) begin
         pb_n++;
         pb_bits = {pb_bits[2:0], ib.out_data};
      end
   end

   task automatic drive(input bit d, input bit c, input bit s);
      @(negedge clk);
      #1;
      din = d; ic = c; st = s;
   endtask

   task automatic send_bits(input logic [63:0] val, input int n, input bit msbfirst);
      for (int i = 0; i < n; i++) drive(val[msbfirst ? (n - 1 - i) : i], 1'b1, 1'b0);
   endtask

   int n0;
   int len;

   initial begin
      rst = 1'b0; din = 1'b0; ic = 1'b0; st = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk); #1 rst = 1'b0;

      // Abort a frame with an asynchronous reset at bit_count 12.
      send_bits(64'hABC, 12, 1'b0);
      drive(0, 0, 0);
      chk("lit A.bit_count=12", 64'(ia.bit_count), 64'd12);
      #2 rst = 1'b1;
      #1;
      chk("lit A.bit_count rst", 64'(ia.bit_count), 64'd0);
      chk("lit B.out_clk rst",   64'(ib.out_clk),   64'd0);
      chk("lit B.out_data rst",  64'(ib.out_data),  64'd0);
      chk("lit B.bit_count rst", 64'(ib.bit_count), 64'd0);
      @(negedge clk); #1 rst = 1'b0;

      // 30-bit LSB-first word; the 8-bit node keeps the first 8 bits MSB-first.
      send_bits(64'h2AAA5555, 30, 1'b0);
      drive(0, 0, 1);
      drive(0, 0, 0);
      chk("lit A.output_data", 64'(ia.output_data), 64'h2AAA5555);
      chk("lit A.frame_valid", 64'(ia.frame_valid), 64'd1);
      chk("lit A.short_frame", 64'(ia.short_frame), 64'd0);
      chk("lit B.output_data", 64'(ib.output_data), 64'hAA);
      drive(0, 0, 0);
      chk("lit A.frame_valid end", 64'(ia.frame_valid), 64'd0);

      // 0xA5 MSB-first into the 8-bit node; too short for the 30-bit node.
      send_bits(64'hA5, 8, 1'b1);
      drive(0, 0, 1);
      drive(0, 0, 0);
      chk("lit B.output_data A5", 64'(ib.output_data), 64'hA5);
      chk("lit B.frame_valid A5", 64'(ib.frame_valid), 64'd1);
      chk("lit A.short_frame",    64'(ia.short_frame), 64'd1);
      chk("lit A.output_data kept", 64'(ia.output_data), 64'h2AAA5555);
      chk("lit A.bit_count cleared", 64'(ia.bit_count), 64'd0);

      // Forwarding: 8 own bits, then 1,0,1,1 go downstream.
      n0 = pb_n;
      send_bits(64'h3C, 8, 1'b1);
      send_bits(64'b1011, 4, 1'b1);
      drive(0, 0, 0);
      chk("lit B.bit_count full", 64'(ib.bit_count), 64'd8);
      chk("lit B.fwd pulses",     64'(pb_n - n0),    64'd4);
      chk("lit B.fwd bits",       64'(pb_bits),      64'b1011);
      drive(0, 0, 1);
      drive(0, 0, 0);
      chk("lit B.out_store",   64'(ib.out_store),   64'd1);
      chk("lit B.output_data 3C", 64'(ib.output_data), 64'h3C);

      // Store coinciding with a bit on a FULL node.
      send_bits(64'h5A, 8, 1'b1);
      drive(1, 1, 1);
      drive(0, 0, 0);
      chk("lit B.frame_valid sim", 64'(ib.frame_valid), 64'd1);
      chk("lit B.output_data 5A",  64'(ib.output_data), 64'h5A);
      chk("lit B.out_clk sim",     64'(ib.out_clk),     64'd0);
      chk("lit B.bit_count sim",   64'(ib.bit_count),   64'd1);

      // Back-to-back stores.
      drive(0, 0, 1);
      drive(0, 0, 1);
      drive(0, 0, 0);
      chk("lit B.short_frame b2b", 64'(ib.short_frame), 64'd1);

      // Randomized frames of mixed length, gaps and strobe collisions.
      for (int f = 0; f < 250; f++) begin
         len = $urandom_range(0, 36);
         if (f % 3 == 0) len = ($urandom_range(0, 1) == 1) ? 30 : 8;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'($urandom), 0, 0);
            drive(1'($urandom), 1, 0);
         end
         drive(1'($urandom), ($urandom_range(0, 3) == 0), 1);
         if ($urandom_range(0, 7) == 0) drive(1'($urandom), 1'($urandom), 1);
         if ($urandom_range(0, 1) == 0) drive(0, 0, 0);
      end
      drive(0, 0, 0);
      drive(0, 0, 0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/serial2parallel_chain.md
# serial2parallel_chain

Parametrised, daisy-chainable serial-to-parallel receiver for the smart-LED datapath. It counts bits into a WIDTH-bit shift register, which can be LSB- or MSB-first. Once its own word is full, it forwards every further bit, together with a delayed store strobe, to the next node in the chain. A store strobe presents the word on `output_data` only when exactly WIDTH bits were received; otherwise it flags a short frame.

## Interface
- `WIDTH`, default 30: data word width, legal range 2..64.
- `MSB_FIRST`, default 0: 0 means the first received bit lands in bit 0; 1 means it lands in bit WIDTH-1.
- `clk`  input  1: single system clock; all logic runs on the rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `in_data`  input  1: serial bit, sampled only when `in_clk`=1.
- `in_clk`  input  1: bit strobe, synchronous enable, one clk cycle per bit.
- `store`  input  1: frame-end strobe, synchronous, one cycle.
- `output_data`  output  WIDTH: last valid captured word.
- `frame_valid`  output  1: one-cycle pulse when `output_data` is updated.
- `short_frame`  output  1: sticky error flag, set by a store with fewer than WIDTH bits received.
- `bit_count`  output  $clog2(WIDTH+1): number of bits held in the current frame, 0..WIDTH.
- `out_data`  output  1: forwarded serial bit to the downstream node.
- `out_clk`  output  1: forwarded bit strobe.
- `out_store`  output  1: forwarded frame-end strobe.

## Operation
- States are derived from `bit_count`:
  - FILL: `bit_count` < WIDTH.
  - FULL: `bit_count` == WIDTH.
- FILL, `in_clk`=1:
  - MSB_FIRST=0: shift register shifts right; `in_data` enters bit WIDTH-1.
  - MSB_FIRST=1: shift register shifts left; `in_data` enters bit 0.
  - `bit_count` increments by 1.
- FULL, `in_clk`=1:
  - Shift register and `bit_count` are unchanged.
  - `out_data` <= `in_data`; `out_clk` <= 1 for one cycle.
  - There is no wrap-around; the 31st and later bits (WIDTH=30) go downstream only.
- `out_clk` is 0 in every cycle without a forwarded bit. `out_data` holds its last value.
- `store`=1 when `bit_count`==WIDTH:
  - `output_data` <= shift register; `frame_valid` pulses.
  - `short_frame` clears.
- `store`=1 when `bit_count`<WIDTH (this includes 0):
  - `output_data` is unchanged and there is no `frame_valid` pulse.
  - `short_frame` <= 1.
- Every store sets `bit_count` to 0. The shift register contents are kept, not cleared.
- `out_store` <= `store` every cycle, regardless of state, so the downstream node latches in the same frame.
- `store` and `in_clk` in the same cycle:
  - The store evaluates the pre-cycle `bit_count` and shift register.
  - The strobed bit becomes bit 1 of the next frame: it is shifted in and `bit_count` becomes 1.
  - It is never forwarded, even if the node was FULL.
- Reset value of every output and register is 0: `output_data`, `frame_valid`, `short_frame`, `bit_count`, `out_data`, `out_clk`, `out_store`, and the shift register.
- Reset asserted mid-frame aborts the frame. After release, the node starts in FILL with `bit_count`=0.

## Timing
- Shift and count take effect on the edge where `in_clk`=1. `bit_count` is visible the following cycle.
- Forwarding latency is 1 cycle: `in_clk` at edge n produces `out_clk`/`out_data` high/valid after edge n, for exactly one cycle.
- `out_store` has 1-cycle latency relative to `store`. A chain of N nodes therefore delays the store by N cycles.
- `output_data`, `frame_valid` and `short_frame` update on the `store` edge and are valid the next cycle. `frame_valid` lasts one cycle.
- Back-to-back `in_clk` strobes on every cycle are supported, with no gap required.
- `store` strobes on consecutive cycles are supported:
  - The second store sees `bit_count`=0, or 1 if `in_clk` coincided.
  - It therefore sets `short_frame`.
- Asynchronous reset assertion clears all state immediately. Deassertion is expected synchronous to `clk`, handled by the system reset synchroniser.

## Test plan
- Reset: assert `rst` mid-frame with `bit_count`=12 → all outputs 0 immediately. After release, 30 bits followed by `store` → `frame_valid`=1 and `output_data` matches the sent word.
- LSB-first, WIDTH=30: send 0x2AAA_5555 bit 0 first, then `store` → `output_data`=0x2AAA5555, `frame_valid` pulses once, `short_frame`=0.
- MSB_FIRST=1, WIDTH=8: send 0xA5 MSB first, then `store` → `output_data`=0xA5.
- Forwarding, WIDTH=8: send 12 bits, pattern 8×own then 1,0,1,1 → `out_clk` pulses 4 times, each 1 cycle after its `in_clk`, with `out_data` carrying 1,0,1,1. `bit_count` stays 8. The `store` produces `out_store` 1 cycle later.
- Short frame: send 5 bits into WIDTH=8, then `store` → `output_data` keeps its previous value, `short_frame`=1, `bit_count`=0. A following full frame plus `store` clears `short_frame`.
- Simultaneous events: FULL node, `store` and `in_clk` (data=1) in the same cycle → the old word is latched, `frame_valid` pulses, `out_clk` does not pulse, and `bit_count`=1 the next cycle.
